leitor_placar_display: RTL
==========================

// Module: leitor_placar_display
// PURPOSE
//  Receiving end of the scoreboard's multiplexed 7-segment interface: samples segment bus + digit select,
//  filters glitches, decodes each digit back to BCD, rebuilds both teams' 0-99 scores in binary.
//  Used as a remote-scoreboard receiver and as an on-board self-check monitor of the display path.
// PARAMETERS
//  ESTAVEL_CICLOS     4        identical consecutive samples needed before a digit is accepted (>=1)
//  TIMEOUT_CICLOS     1000000  cycles without an accepted digit before semSinal asserts (20 ms @50 MHz)
//  SEG_ATIVO_BAIXO    1        1: segment lit when bit=0
//  ANODO_ATIVO_BAIXO  1        1: digit selected when escolhaDisplay bit=0
// PORTS
//  clock           in   1  system clock, rising edge
//  nReset          in   1  asynchronous, active-low reset
//  display         in   7  segment bus, bit0=a .. bit6=g
//  escolhaDisplay  in   4  digit select: [0]=units A, [1]=tens A, [2]=units B, [3]=tens B
//  limparErro      in   1  clears erroSegmento
//  placarTimeA     out  7  team A score, binary 0-99
//  placarTimeB     out  7  team B score, binary 0-99
//  novoPlacarA     out  1  1-cycle pulse: placarTimeA updated
//  novoPlacarB     out  1  1-cycle pulse: placarTimeB updated
//  erroSegmento    out  1  sticky: undecodable segment pattern accepted
//  semSinal        out  1  no digit accepted for TIMEOUT_CICLOS cycles
// BEHAVIOUR
//  - Reset (async): all outputs 0, digit regs 0, seen bits 0, FSM OCIOSO, timeout counter 0. Mid-operation
//    reset discards any partial capture immediately.
//  - display/escolhaDisplay pass a 2-flop synchronizer; internally inverted per polarity params.
//  - Sample = {anode, segments}. Valid anode = exactly one digit selected; 0 or >1 selected = invalid.
//  - FSM: OCIOSO: valid sample -> ESTAVEL, snapshot<=sample, cnt<=1.
//    ESTAVEL: sample==snapshot -> cnt++; cnt reaches ESTAVEL_CICLOS -> CAPTURA.
//      sample differs & valid -> restart (new snapshot, cnt=1); differs & invalid -> OCIOSO.
//    CAPTURA (1 cycle): decode, write digit reg -> ESPERA_TROCA.
//    ESPERA_TROCA: hold while sample==snapshot; any change -> OCIOSO (evaluated next cycle).
//  - Decode: standard 0-9; 6 and 9 accepted with or without tail segment; blank (no segment) = 0
//    (leading-zero suppression). Any other pattern: erroSegmento<=1, digit reg and seen bit unchanged.
//  - Good decode sets seen bit of that position. When units and tens of a team are both seen:
//    value = tens*10+units (max 99, 7 bits); both seen bits of that team cleared same cycle.
//    If value differs from held score, or is the first publication since reset: score reg <= value
//    and novoPlacarX pulses 1 cycle. Otherwise no update, no pulse.
//  - At most one capture per cycle, so A and B never publish in the same cycle.
//  - Latency: last required stable input sample -> score/pulse = 2 (sync) + 1 (CAPTURA) + 1 (publish) cycles.
//  - erroSegmento clears on limparErro; new error in the same cycle wins (stays 1).
//  - Timeout counter: cleared on each CAPTURA, else increments, saturating; semSinal = (cnt>=TIMEOUT_CICLOS).
//    semSinal drops the cycle after the next CAPTURA. Counter widths via $clog2 of the parameters.
// TESTING (active-low; bench uses ESTAVEL_CICLOS=4, TIMEOUT_CICLOS=16)
//  1 Reset: pulse nReset=0 during ESTAVEL -> all outputs 0 at once; no pulse after release.
//  2 escolhaDisplay=4'b1110 display=7'b0110000 ("3") 8 cycles, then 4'b1101 7'b0100100 ("2") 8 cycles
//    -> placarTimeA=23, exactly one novoPlacarA pulse; placarTimeB=0, novoPlacarB never pulses.
//  3 Glitch: display toggles "3"/"2" every 2 cycles on 4'b1110 -> no capture, no pulse, semSinal=1 after 16+.
//  4 Invalid pattern 7'b1110110 (a+d only) held 8 cycles on 4'b1011 -> erroSegmento=1, no B publish;
//    limparErro 1 cycle -> erroSegmento=0.
//  5 escolhaDisplay=4'b1100 (two digits) 20 cycles -> no capture, semSinal=1; then valid "7" capture
//    -> semSinal=0.
//  6 After test 2, re-send "3","2" -> no pulse; send units "7" (7'b1111000) then tens "2" -> placarTimeA=27, one pulse.

Source files
------------

// File: rtl/leitor_placar_display.sv
// Scoreboard display receiver: samples a multiplexed 7-segment bus, debounces each digit,
// decodes it back to BCD and rebuilds both teams' 0-99 scores.
module leitor_placar_display #(
  parameter int unsigned ESTAVEL_CICLOS    = 4,
  parameter int unsigned TIMEOUT_CICLOS    = 1000000,
  parameter bit          SEG_ATIVO_BAIXO   = 1'b1,
  parameter bit          ANODO_ATIVO_BAIXO = 1'b1
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic [6:0] display,
  input  logic [3:0] escolhaDisplay,
  input  logic       limparErro,
  output logic [6:0] placarTimeA,
  output logic [6:0] placarTimeB,
  output logic       novoPlacarA,
  output logic       novoPlacarB,
  output logic       erroSegmento,
  output logic       semSinal
);

  localparam int unsigned EST_W = $clog2(ESTAVEL_CICLOS + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CICLOS + 1);
  localparam int unsigned SMP_W = 11;

  typedef enum logic [1:0] {OCIOSO, ESTAVEL, CAPTURA, ESPERA_TROCA} estado_t;

  logic [6:0]       seg_s1, seg_s2;
  logic [3:0]       an_s1, an_s2;
  logic [6:0]       seg;
  logic [3:0]       an;
  logic [SMP_W-1:0] amostra;
  logic             valido;

  estado_t          estado, estado_n;
  logic [SMP_W-1:0] snap, snap_n;
  logic [EST_W-1:0] cnt, cnt_n;
  logic             captura;

  logic             dec_ok;
  logic [3:0]       dec_val;
  logic [3:0][3:0]  digito;
  logic [3:0]       visto;
  logic             pub_a, pub_b;
  logic [6:0]       valor_a, valor_b;
  logic [TO_W-1:0]  to_cnt, to_n;

  // Standard 7-segment decode (bit0=a); 6 and 9 with or without tail, blank reads as 0
  function automatic logic [4:0] decodifica(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h00, 7'h3F: r = 5'b1_0000;
      7'h06:        r = 5'b1_0001;
      7'h5B:        r = 5'b1_0010;
      7'h4F:        r = 5'b1_0011;
      7'h66:        r = 5'b1_0100;
      7'h6D:        r = 5'b1_0101;
      7'h7D, 7'h7C: r = 5'b1_0110;
      7'h07:        r = 5'b1_0111;
      7'h7F:        r = 5'b1_1000;
      7'h6F, 7'h67: r = 5'b1_1001;
      default:      r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer on the asynchronous display bus
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      an_s1  <= '0;
      an_s2  <= '0;
    end else begin
      seg_s1 <= display;
      seg_s2 <= seg_s1;
      an_s1  <= escolhaDisplay;
      an_s2  <= an_s1;
    end
  end

  assign seg     = SEG_ATIVO_BAIXO ? ~seg_s2 : seg_s2;
  assign an      = ANODO_ATIVO_BAIXO ? ~an_s2 : an_s2;
  assign amostra = {an, seg};
  assign valido  = (an != 4'd0) && ((an & (an - 4'd1)) == 4'd0);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      estado <= OCIOSO;
      snap   <= '0;
      cnt    <= '0;
    end else begin
      estado <= estado_n;
      snap   <= snap_n;
      cnt    <= cnt_n;
    end
  end

  // Debounce: a digit is taken once the same valid sample repeats ESTAVEL_CICLOS times
  always_comb begin
    estado_n = estado;
    snap_n   = snap;
    cnt_n    = cnt;
    case (estado)
      OCIOSO: begin
        if (valido) begin
          snap_n   = amostra;
          cnt_n    = EST_W'(1);
          estado_n = (ESTAVEL_CICLOS <= 1) ? CAPTURA : ESTAVEL;
        end
      end
      ESTAVEL: begin
        if (amostra == snap) begin
          cnt_n = cnt + EST_W'(1);
          if ((32'(cnt) + 32'd1) >= ESTAVEL_CICLOS) estado_n = CAPTURA;
        end else if (valido) begin
          snap_n = amostra;
          cnt_n  = EST_W'(1);
        end else begin
          estado_n = OCIOSO;
        end
      end
      CAPTURA:      estado_n = ESPERA_TROCA;
      ESPERA_TROCA: if (amostra != snap) estado_n = OCIOSO;
      default:      estado_n = OCIOSO;
    endcase
  end

  assign captura          = (estado == CAPTURA);
  assign {dec_ok, dec_val} = decodifica(snap[6:0]);
  assign valor_a          = 7'(digito[1]) * 7'd10 + 7'(digito[0]);
  assign valor_b          = 7'(digito[3]) * 7'd10 + 7'(digito[2]);

  // Digit capture, score publication and sticky decode error
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      digito       <= '0;
      visto        <= '0;
      pub_a        <= 1'b0;
      pub_b        <= 1'b0;
      placarTimeA  <= '0;
      placarTimeB  <= '0;
      novoPlacarA  <= 1'b0;
      novoPlacarB  <= 1'b0;
      erroSegmento <= 1'b0;
    end else begin
      novoPlacarA <= 1'b0;
      novoPlacarB <= 1'b0;
      if (&visto[1:0]) begin
        visto[1:0] <= 2'b00;
        pub_a      <= 1'b1;
        if (!pub_a || (valor_a != placarTimeA)) begin
          placarTimeA <= valor_a;
          novoPlacarA <= 1'b1;
        end
      end
      if (&visto[3:2]) begin
        visto[3:2] <= 2'b00;
        pub_b      <= 1'b1;
        if (!pub_b || (valor_b != placarTimeB)) begin
          placarTimeB <= valor_b;
          novoPlacarB <= 1'b1;
        end
      end
      if (captura && dec_ok) begin
        for (int i = 0; i < 4; i++) begin
          if (snap[7+i]) begin
            digito[i] <= dec_val;
            visto[i]  <= 1'b1;
          end
        end
      end
      if (captura && !dec_ok) erroSegmento <= 1'b1;
      else if (limparErro)    erroSegmento <= 1'b0;
    end
  end

  // Loss-of-signal watchdog, restarted by every capture
  always_comb begin
    to_n = to_cnt;
    if (captura) to_n = '0;
    else if (to_cnt < TO_W'(TIMEOUT_CICLOS)) to_n = to_cnt + TO_W'(1);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      to_cnt   <= '0;
      semSinal <= 1'b0;
    end else begin
      to_cnt   <= to_n;
      semSinal <= (to_n >= TO_W'(TIMEOUT_CICLOS));
    end
  end

endmodule
